// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit RISC datapath: opcodes, control FSM states and bus select codes.
// Used by both the control unit and the ALU.
package risc_pkg;

    localparam int WORD_WIDTH  = 8;
    localparam int OPCODE_SIZE = 4;
    localparam int SEL1_SIZE   = 3;
    localparam int SEL2_SIZE   = 2;

    localparam logic [OPCODE_SIZE-1:0] OP_NOP = 4'd0;
    localparam logic [OPCODE_SIZE-1:0] OP_ADD = 4'd1;
    localparam logic [OPCODE_SIZE-1:0] OP_SUB = 4'd2;
    localparam logic [OPCODE_SIZE-1:0] OP_AND = 4'd3;
    localparam logic [OPCODE_SIZE-1:0] OP_NOT = 4'd4;
    localparam logic [OPCODE_SIZE-1:0] OP_RD  = 4'd5;
    localparam logic [OPCODE_SIZE-1:0] OP_WR  = 4'd6;
    localparam logic [OPCODE_SIZE-1:0] OP_BR  = 4'd7;
    localparam logic [OPCODE_SIZE-1:0] OP_BRZ = 4'd8;

    localparam logic [SEL1_SIZE-1:0] SEL1_PC   = 3'd4;

    localparam logic [SEL2_SIZE-1:0] SEL2_ALU  = 2'd0;
    localparam logic [SEL2_SIZE-1:0] SEL2_BUS1 = 2'd1;
    localparam logic [SEL2_SIZE-1:0] SEL2_MEM  = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EX1  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11
    } state_t;

endpackage

// File: rtl/risc_ctrl_decode.sv
// Combinational next-state and control decode for the RISC control FSM.
// Every control is a pure function of the current state, the IR contents and the zero flag.
import risc_pkg::*;

module risc_ctrl_decode (
    input  state_t      state,
    input  logic [7:0]  instruction,
    input  logic        zflag,
    output state_t      next_state,
    output logic [3:0]  alu_select,
    output logic [3:0]  load_reg,
    output logic        load_pc,
    output logic        inc_pc,
    output logic        load_ir,
    output logic        load_add_r,
    output logic        load_reg_y,
    output logic        load_reg_z,
    output logic [2:0]  sel_bus_1,
    output logic [1:0]  sel_bus_2,
    output logic        write,
    output logic        halted
);

    logic [3:0] opcode;
    logic [1:0] src;
    logic [1:0] dest;
    logic [3:0] dest_onehot;

    assign opcode      = instruction[7:4];
    assign src         = instruction[3:2];
    assign dest        = instruction[1:0];
    assign dest_onehot = 4'b0001 << dest;

    always_comb begin
        next_state = S_IDLE;
        alu_select = OP_NOP;
        load_reg   = 4'b0000;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        load_ir    = 1'b0;
        load_add_r = 1'b0;
        load_reg_y = 1'b0;
        load_reg_z = 1'b0;
        sel_bus_1  = 3'd0;
        sel_bus_2  = 2'd0;
        write      = 1'b0;
        halted     = 1'b0;

        case (state)
            S_IDLE: next_state = S_FET1;
            S_FET1: begin
                sel_bus_1  = SEL1_PC;
                sel_bus_2  = SEL2_BUS1;
                load_add_r = 1'b1;
                inc_pc     = 1'b1;
                next_state = S_FET2;
            end
            S_FET2: begin
                sel_bus_2  = SEL2_MEM;
                load_ir    = 1'b1;
                next_state = S_DEC;
            end
            S_DEC: begin
                case (opcode)
                    OP_NOP: next_state = S_FET1;
                    OP_ADD, OP_SUB, OP_AND: begin
                        sel_bus_1  = {1'b0, src};
                        sel_bus_2  = SEL2_BUS1;
                        load_reg_y = 1'b1;
                        next_state = S_EX1;
                    end
                    OP_NOT: begin
                        alu_select = OP_NOT;
                        sel_bus_1  = {1'b0, src};
                        sel_bus_2  = SEL2_ALU;
                        load_reg   = dest_onehot;
                        load_reg_z = 1'b1;
                        next_state = S_FET1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        sel_bus_1  = SEL1_PC;
                        sel_bus_2  = SEL2_BUS1;
                        load_add_r = 1'b1;
                        inc_pc     = 1'b1;
                        next_state = (opcode == OP_RD) ? S_RD1 :
                                     (opcode == OP_WR) ? S_WR1 : S_BR1;
                    end
                    OP_BRZ: begin
                        // Not-taken BRZ still has to step the PC past its address byte.
                        inc_pc = 1'b1;
                        if (zflag) begin
                            sel_bus_1  = SEL1_PC;
                            sel_bus_2  = SEL2_BUS1;
                            load_add_r = 1'b1;
                            next_state = S_BR1;
                        end else begin
                            next_state = S_FET1;
                        end
                    end
                    default: next_state = S_HALT;
                endcase
            end
            S_EX1: begin
                alu_select = opcode;
                sel_bus_1  = {1'b0, dest};
                sel_bus_2  = SEL2_ALU;
                load_reg   = dest_onehot;
                load_reg_z = 1'b1;
                next_state = S_FET1;
            end
            S_RD1, S_WR1, S_BR1: begin
                sel_bus_2  = SEL2_MEM;
                load_add_r = 1'b1;
                next_state = (state == S_RD1) ? S_RD2 :
                             (state == S_WR1) ? S_WR2 : S_BR2;
            end
            S_RD2: begin
                sel_bus_2  = SEL2_MEM;
                load_reg   = dest_onehot;
                next_state = S_FET1;
            end
            S_WR2: begin
                sel_bus_1  = {1'b0, src};
                write      = 1'b1;
                next_state = S_FET1;
            end
            S_BR2: begin
                sel_bus_2  = SEL2_MEM;
                load_pc    = 1'b1;
                next_state = S_FET1;
            end
            S_HALT: begin
                halted     = 1'b1;
                next_state = S_HALT;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: rtl/risc_control_unit.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit RISC datapath.
// Holds only the state register; all controls come from the combinational decoder.
import risc_pkg::*;

module risc_control_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  instruction,
    input  logic        zflag,
    output logic [3:0]  alu_select,
    output logic [3:0]  load_reg,
    output logic        load_pc,
    output logic        inc_pc,
    output logic        load_ir,
    output logic        load_add_r,
    output logic        load_reg_y,
    output logic        load_reg_z,
    output logic [2:0]  sel_bus_1,
    output logic [1:0]  sel_bus_2,
    output logic        write,
    output logic        halted
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    risc_ctrl_decode u_decode (
        .state       (state_q),
        .instruction (instruction),
        .zflag       (zflag),
        .next_state  (state_d),
        .alu_select  (alu_select),
        .load_reg    (load_reg),
        .load_pc     (load_pc),
        .inc_pc      (inc_pc),
        .load_ir     (load_ir),
        .load_add_r  (load_add_r),
        .load_reg_y  (load_reg_y),
        .load_reg_z  (load_reg_z),
        .sel_bus_1   (sel_bus_1),
        .sel_bus_2   (sel_bus_2),
        .write       (write),
        .halted      (halted)
    );

endmodule
